// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - flit field map, port codes and flit type shared by the router stages
`timescale 1ns/1ps
package router_pkg;

    localparam int FLIT_W   = 32;

    // Flit field offsets; bits [31:20] are payload and are never interpreted here
    localparam int GOLD_B   = 0;
    localparam int EJ_B     = 1;
    localparam int INP_LSB  = 2;
    localparam int INP_MSB  = 3;
    localparam int OUTP_LSB = 4;
    localparam int OUTP_MSB = 6;
    localparam int SRC_LSB  = 7;
    localparam int SRC_MSB  = 10;
    localparam int DST_LSB  = 11;
    localparam int DST_MSB  = 14;
    localparam int SEQ_LSB  = 15;
    localparam int SEQ_MSB  = 19;
    localparam int SEQ_W    = SEQ_MSB - SEQ_LSB + 1;

    // Output port codes; 101-111 are undefined and behave as non-local
    localparam logic [2:0] P_N     = 3'b000;
    localparam logic [2:0] P_E     = 3'b001;
    localparam logic [2:0] P_S     = 3'b010;
    localparam logic [2:0] P_W     = 3'b011;
    localparam logic [2:0] P_LOCAL = 3'b100;

    typedef logic [FLIT_W-1:0] flit_t;

    // A flit asks for the local port only with the exact LOCAL code
    function automatic logic wants_local(flit_t f);
        return f[OUTP_MSB:OUTP_LSB] == P_LOCAL;
    endfunction

    function automatic logic [SEQ_W-1:0] seq_of(flit_t f);
        return f[SEQ_MSB:SEQ_LSB];
    endfunction

endpackage

// File: rtl/eject_cmp.sv
// rtl/eject_cmp.sv - two-way ejection priority compare (golden, then lowest sequence, then higher slot)
`timescale 1ns/1ps
module eject_cmp
    import router_pkg::*;
(
    input  logic             a_req,
    input  logic             a_gold,
    input  logic [SEQ_W-1:0] a_seq,
    input  logic [1:0]       a_idx,
    input  logic             b_req,
    input  logic             b_gold,
    input  logic [SEQ_W-1:0] b_seq,
    input  logic [1:0]       b_idx,
    output logic             o_req,
    output logic             o_gold,
    output logic [SEQ_W-1:0] o_seq,
    output logic [1:0]       o_idx
);

    logic pick_b;

    // Decide which tuple is stronger; the ordering is total, so a tree of these is consistent
    always_comb begin
        pick_b = 1'b0;
        if (!a_req) begin
            pick_b = 1'b1;
        end else if (!b_req) begin
            pick_b = 1'b0;
        end else if (a_gold != b_gold) begin
            pick_b = b_gold;
        end else if (a_gold && (a_seq != b_seq)) begin
            pick_b = (b_seq < a_seq);
        end else begin
            pick_b = (b_idx > a_idx);
        end
    end

    // Forward the chosen tuple
    always_comb begin
        o_req  = pick_b ? b_req  : a_req;
        o_gold = pick_b ? b_gold : a_gold;
        o_seq  = pick_b ? b_seq  : a_seq;
        o_idx  = pick_b ? b_idx  : a_idx;
    end

endmodule

// File: rtl/eject_engine.sv
// rtl/eject_engine.sv - deflection-router ejection stage: pick one local-bound flit, mark it, register all slots
`timescale 1ns/1ps
module eject_engine
    import router_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_0,
    input  logic [31:0] in_1,
    input  logic [31:0] in_2,
    input  logic [31:0] in_3,
    output logic [31:0] outN,
    output logic [31:0] outE,
    output logic [31:0] outS,
    output logic [31:0] outW,
    output logic [31:0] eject_flit,
    output logic        eject_valid
);

    flit_t            in_s [4];
    logic [3:0]       req;
    logic [3:0]       gold;

    logic             lo_req,  hi_req,  win_req;
    logic             lo_gold, hi_gold, win_gold;
    logic [SEQ_W-1:0] lo_seq,  hi_seq,  win_seq;
    logic [1:0]       lo_idx,  hi_idx,  win_idx;

    logic [3:0]       win_oh;
    flit_t            slot_d [4];
    flit_t            slot_q [4];
    flit_t            eject_flit_d, eject_flit_q;
    logic             eject_valid_d, eject_valid_q;

    assign in_s[0] = in_0;
    assign in_s[1] = in_1;
    assign in_s[2] = in_2;
    assign in_s[3] = in_3;

    // Per-slot request and golden flags; an incoming ejected mark plays no part
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req[i]  = wants_local(in_s[i]);
            gold[i] = in_s[i][GOLD_B];
        end
    end

    eject_cmp u_cmp_ne (
        .a_req  (req[0]),  .a_gold (gold[0]), .a_seq (seq_of(in_s[0])), .a_idx (2'd0),
        .b_req  (req[1]),  .b_gold (gold[1]), .b_seq (seq_of(in_s[1])), .b_idx (2'd1),
        .o_req  (lo_req),  .o_gold (lo_gold), .o_seq (lo_seq),           .o_idx (lo_idx)
    );

    eject_cmp u_cmp_sw (
        .a_req  (req[2]),  .a_gold (gold[2]), .a_seq (seq_of(in_s[2])), .a_idx (2'd2),
        .b_req  (req[3]),  .b_gold (gold[3]), .b_seq (seq_of(in_s[3])), .b_idx (2'd3),
        .o_req  (hi_req),  .o_gold (hi_gold), .o_seq (hi_seq),           .o_idx (hi_idx)
    );

    eject_cmp u_cmp_fin (
        .a_req  (lo_req),  .a_gold (lo_gold), .a_seq (lo_seq),  .a_idx (lo_idx),
        .b_req  (hi_req),  .b_gold (hi_gold), .b_seq (hi_seq),  .b_idx (hi_idx),
        .o_req  (win_req), .o_gold (win_gold), .o_seq (win_seq), .o_idx (win_idx)
    );

    // Build the one-hot winner and the next slot / eject values; only bit EJ_B is rewritten
    always_comb begin
        win_oh = 4'b0000;
        if (win_req) begin
            win_oh[win_idx] = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            slot_d[i]       = in_s[i];
            slot_d[i][EJ_B] = win_oh[i];
        end
        eject_valid_d = win_req;
        eject_flit_d  = win_req ? slot_d[win_idx] : '0;
    end

    // Single pipeline register for all outputs; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
            eject_flit_q  <= '0;
            eject_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= slot_d[i];
            end
            eject_flit_q  <= eject_flit_d;
            eject_valid_q <= eject_valid_d;
        end
    end

    assign outN        = slot_q[0];
    assign outE        = slot_q[1];
    assign outS        = slot_q[2];
    assign outW        = slot_q[3];
    assign eject_flit  = eject_flit_q;
    assign eject_valid = eject_valid_q;

    // win_gold and win_seq only steer the tree; they are not needed past the root
    logic unused_ok;
    assign unused_ok = win_gold ^ (^win_seq);

endmodule

// File: tb/tb_eject_engine.sv
// tb/tb_eject_engine.sv - scoreboard bench for eject_engine with randomized flits and a reference model
`timescale 1ns/1ps
module tb_eject_engine;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_0, in_1, in_2, in_3;
    logic [31:0] outN, outE, outS, outW;
    logic [31:0] eject_flit;
    logic        eject_valid;

    typedef struct packed {
        logic [3:0][31:0] o;
        logic [31:0]      ef;
        logic             ev;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    eject_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_0        (in_0),
        .in_1        (in_1),
        .in_2        (in_2),
        .in_3        (in_3),
        .outN        (outN),
        .outE        (outE),
        .outS        (outS),
        .outW        (outW),
        .eject_flit  (eject_flit),
        .eject_valid (eject_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference: among local requesters, prefer golden ones; golden by smallest seq,
    // ties and non-golden by highest slot index.
    function automatic exp_t model(input logic [3:0][31:0] f);
        exp_t e;
        int   win = -1;
        bit   any_gold = 0;
        for (int i = 0; i < 4; i++)
            if (f[i][6:4] == 3'b100 && f[i][0]) any_gold = 1;
        for (int i = 0; i < 4; i++) begin
            if (f[i][6:4] == 3'b100 && (!any_gold || f[i][0])) begin
                if (win < 0 || !any_gold || f[i][19:15] <= f[win][19:15]) win = i;
            end
        end
        for (int i = 0; i < 4; i++) begin
            e.o[i]    = f[i];
            e.o[i][1] = (i == win);
        end
        e.ev = (win >= 0);
        e.ef = (win >= 0) ? e.o[win] : 32'h0;
        return e;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d,
                        input bit use_fixed, input exp_t fixed);
        logic [3:0][31:0] f;
        @(negedge clk);
        in_0 = a; in_1 = b; in_2 = c; in_3 = d;
        f = {d, c, b, a};
        q.push_back(use_fixed ? fixed : model(f));
    endtask

    function automatic logic [31:0] rnd_flit();
        logic [31:0] f;
        f = $urandom;
        case ($urandom_range(0, 4))
            0, 1, 2: f[6:4] = 3'b100;
            3:       f[6:4] = 3'($urandom_range(5, 7));
            default: f = 32'h0;
        endcase
        if ($urandom_range(0, 1) == 1) f[19:15] = 5'($urandom_range(16, 18));
        return f;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_outN"}, outN, 32'h0);
        check({tag, "_outE"}, outE, 32'h0);
        check({tag, "_outS"}, outS, 32'h0);
        check({tag, "_outW"}, outW, 32'h0);
        check({tag, "_eflit"}, eject_flit, 32'h0);
        check({tag, "_evalid"}, {31'h0, eject_valid}, 32'h0);
    endtask

    // Monitor: one result per clock, one cycle after the flits were presented
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("outN", outN, e.o[0]);
                check("outE", outE, e.o[1]);
                check("outS", outS, e.o[2]);
                check("outW", outW, e.o[3]);
                check("eject_flit", eject_flit, e.ef);
                check("eject_valid", {31'h0, eject_valid}, {31'h0, e.ev});
            end
        end
    end

    initial begin
        exp_t fx;
        exp_t none;
        none  = '0;
        rst_n = 1'b0;
        in_0 = 32'hdeadbeef; in_1 = 32'h000800c3; in_2 = 32'h12345678; in_3 = 32'hffffffff;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        fx.o[0] = 32'h000800c3; fx.o[1] = 32'h111880c5;
        fx.o[2] = 32'h11090088; fx.o[3] = 32'h1019809c;
        fx.ef = 32'h000800c3;   fx.ev = 1'b1;
        send(32'h000800c3, 32'h111880c7, 32'h1109008a, 32'h1019809e, 1, fx);
        send(32'h000880c2, 32'h111800c7, 32'h1109008a, 32'h1019809e, 0, none);
        send(32'h000800c2, 32'h111880c6, 32'h1109008a, 32'h1019809e, 0, none);
        send(32'h000800c2, 32'h111880c7, 32'h1109008a, 32'h1019809e, 0, none);
        fx.o[0] = 32'h000980c1; fx.o[1] = 32'h11188034;
        fx.o[2] = 32'h11090098; fx.o[3] = 32'h111900cf;
        fx.ef = 32'h111900cf;   fx.ev = 1'b1;
        send(32'h000980c3, 32'h11188036, 32'h1109009a, 32'h111900cf, 1, fx);
        // No local requester, ejected bits set on input and undefined port codes
        fx.o[0] = 32'h00000050; fx.o[1] = 32'habcd0061; fx.o[2] = 32'h00000071; fx.o[3] = 32'h00000031;
        fx.ef = 32'h0; fx.ev = 1'b0;
        send(32'h00000052, 32'habcd0063, 32'h00000073, 32'h00000033, 1, fx);
        send(32'h0, 32'h0, 32'h0, 32'h0, 1, none);
        // Golden tie on sequence between N and S: S must win
        send(32'h00080041, 32'h0, 32'h00080041, 32'h0, 0, none);

        // Randomized traffic
        for (int n = 0; n < 300; n++)
            send(rnd_flit(), rnd_flit(), rnd_flit(), rnd_flit(), 0, none);

        // Mid-stream reset: flits in flight are dropped, outputs clear without a clock edge
        send(32'h000800c3, 32'h111880c7, 32'h1109008a, 32'h1019809e, 0, none);
        send(32'h000880c2, 32'h111800c7, 32'h1109008a, 32'h1019809e, 0, none);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        q.delete();
        @(posedge clk);
        #1;
        check_zero("held_rst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 50; n++)
            send(rnd_flit(), rnd_flit(), rnd_flit(), rnd_flit(), 0, none);

        @(posedge clk);
        #3;
        check("queue_drained", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
